// File: rtl/core_pkg.sv
// core_pkg
//   Shared types and constants for the commit stage and its register file.
//   commit_slot_t  : one retiring ROB entry as seen by the commit stage
//   commit_state_e : commit FSM states (RUN, FLUSH, DRAIN)
//   XLEN, NUM_AREGS: default datapath width and architectural register count
package core_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_AREGS = 32;
  localparam int RD_W      = 5;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            rd_we;
    logic [XLEN-1:0] data;
    logic            exc;
    logic [XLEN-1:0] pc;
  } commit_slot_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } commit_state_e;

endpackage

// File: rtl/arch_reg_file.sv
// arch_reg_file
//   Architectural register file, NUM_AREGS x XLEN, register 0 hardwired to zero.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset (clears all regs)
//     wr_en   [NW]      : per-port write enable, port NW-1 has highest priority
//     wr_addr [NW*5]    : per-port destination register
//     wr_data [NW*XLEN] : per-port write data
//     rd_addr [NR*5]    : read addresses
//     rd_data [NR*XLEN] : combinational read data, no write bypass
module arch_reg_file
  import core_pkg::*;
#(
  parameter int NUM_WR_PORTS = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int XLEN_P       = XLEN,
  parameter int NUM_REGS     = NUM_AREGS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR_PORTS-1:0]         wr_en,
  input  logic [NUM_WR_PORTS*RD_W-1:0]    wr_addr,
  input  logic [NUM_WR_PORTS*XLEN_P-1:0]  wr_data,
  input  logic [NUM_RD_PORTS*RD_W-1:0]    rd_addr,
  output logic [NUM_RD_PORTS*XLEN_P-1:0]  rd_data
);

  logic [XLEN_P-1:0] regs_q [NUM_REGS];
  logic [XLEN_P-1:0] regs_d [NUM_REGS];

  // Ports are applied oldest to youngest so the youngest write to a
  // register overrides older ones in the same cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      if (wr_en[i] && (wr_addr[i*RD_W +: RD_W] != '0) &&
          (int'(wr_addr[i*RD_W +: RD_W]) < NUM_REGS)) begin
        regs_d[wr_addr[i*RD_W +: RD_W]] = wr_data[i*XLEN_P +: XLEN_P];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if ((rd_addr[p*RD_W +: RD_W] != '0) &&
          (int'(rd_addr[p*RD_W +: RD_W]) < NUM_REGS)) begin
        rd_data[p*XLEN_P +: XLEN_P] = regs_q[rd_addr[p*RD_W +: RD_W]];
      end
    end
  end

endmodule

// File: rtl/rob_commit_stage.sv
// rob_commit_stage
//   Retires up to RETIRE_WIDTH in-order ROB entries per cycle into the
//   architectural register file it owns, and turns an excepting entry into a
//   one-cycle flush pulse with redirect to EXC_VECTOR followed by a drain
//   window during which nothing is accepted.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     in_valid/in_ready   : per-slot valid (slot 0 oldest), stage ready
//     in_rd/in_rd_we/in_data/in_exc/in_pc : packed per-slot entry fields
//     rd_addr/rd_data     : combinational A-REG read ports (reg 0 reads 0)
//     flush/redirect_pc   : flush pulse and fetch target while flush=1
//     epc                 : PC of the most recent excepting entry
//     commit_cnt          : registered number of slots committed last edge
//   Optional build macro COMMIT_PERF_CNT_EN adds perf_retired (64b) and
//   perf_flushes (32b) wrapping event counters.
module rob_commit_stage
  import core_pkg::*;
#(
  parameter int              RETIRE_WIDTH = 2,
  parameter int              XLEN_P       = XLEN,
  parameter int              NUM_REGS     = NUM_AREGS,
  parameter int              NUM_RD_PORTS = 2,
  parameter int              FLUSH_CYCLES = 3,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0100
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RETIRE_WIDTH-1:0]               in_valid,
  output logic                                  in_ready,
  input  logic [RETIRE_WIDTH*RD_W-1:0]          in_rd,
  input  logic [RETIRE_WIDTH-1:0]               in_rd_we,
  input  logic [RETIRE_WIDTH*XLEN-1:0]          in_data,
  input  logic [RETIRE_WIDTH-1:0]               in_exc,
  input  logic [RETIRE_WIDTH*XLEN-1:0]          in_pc,
  input  logic [NUM_RD_PORTS*RD_W-1:0]          rd_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0]          rd_data,
  output logic                                  flush,
  output logic [XLEN-1:0]                       redirect_pc,
  output logic [XLEN-1:0]                       epc,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]     commit_cnt
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]                           perf_retired,
  output logic [31:0]                           perf_flushes
`endif
);

  localparam int CW  = $clog2(RETIRE_WIDTH + 1);
  localparam int DCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  commit_state_e      state_q, state_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [CW-1:0]      commit_cnt_q, commit_cnt_d;

  commit_slot_t       slot [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0]      commit_mask;
  logic [RETIRE_WIDTH-1:0]      wr_en;
  logic [RETIRE_WIDTH*RD_W-1:0] wr_addr;
  logic [RETIRE_WIDTH*XLEN-1:0] wr_data;
  logic                         exc_hit;
  logic [XLEN-1:0]              exc_pc;

  // Unpack the flat slot buses into per-slot entries.
  always_comb begin
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      slot[i].rd    = in_rd[i*RD_W +: RD_W];
      slot[i].rd_we = in_rd_we[i];
      slot[i].data  = in_data[i*XLEN +: XLEN];
      slot[i].exc   = in_exc[i];
      slot[i].pc    = in_pc[i*XLEN +: XLEN];
    end
  end

  // Only the contiguous valid prefix from slot 0 is accepted. The first
  // accepted excepting slot and everything younger are discarded, so the
  // exception flag is raised before deciding whether that slot commits.
  always_comb begin
    logic prefix_ok;
    prefix_ok    = in_ready;
    exc_hit      = 1'b0;
    exc_pc       = '0;
    commit_mask  = '0;
    commit_cnt_d = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      prefix_ok = prefix_ok & in_valid[i];
      if (prefix_ok && slot[i].exc && !exc_hit) begin
        exc_hit = 1'b1;
        exc_pc  = slot[i].pc;
      end
      commit_mask[i] = prefix_ok & ~exc_hit;
      if (commit_mask[i]) begin
        commit_cnt_d = commit_cnt_d + CW'(1);
      end
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      wr_en[i]                = commit_mask[i] & slot[i].rd_we;
      wr_addr[i*RD_W +: RD_W] = slot[i].rd;
      wr_data[i*XLEN +: XLEN] = slot[i].data;
    end
  end

  arch_reg_file #(
    .NUM_WR_PORTS (RETIRE_WIDTH),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .XLEN_P       (XLEN),
    .NUM_REGS     (NUM_REGS)
  ) u_arf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // FSM state register plus the commit-side status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      drain_cnt_q  <= '0;
      epc_q        <= '0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      epc_q        <= epc_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Next state. DRAIN holds for FLUSH_CYCLES-1 down to 0 inclusive, which
  // together with the single FLUSH cycle keeps in_ready low for
  // 1+FLUSH_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    epc_d       = exc_hit ? exc_pc : epc_q;
    case (state_q)
      RUN: begin
        if (exc_hit) state_d = FLUSH;
      end
      FLUSH: begin
        drain_cnt_d = DCW'(FLUSH_CYCLES - 1);
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_q == '0) state_d = RUN;
        else drain_cnt_d = drain_cnt_q - DCW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == RUN);
    flush       = (state_q == FLUSH);
    redirect_pc = (state_q == FLUSH) ? EXC_VECTOR : '0;
  end

  assign epc        = epc_q;
  assign commit_cnt = commit_cnt_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Both counters wrap naturally on overflow.
  always_comb begin
    perf_retired_d = perf_retired_q + 64'(commit_cnt_q);
    perf_flushes_d = perf_flushes_q + {31'd0, flush};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_rob_commit_stage.sv
// tb_rob_commit_stage
//   Directed bench for rob_commit_stage with RETIRE_WIDTH=2, XLEN=32,
//   FLUSH_CYCLES=3, EXC_VECTOR=0x100. Covers the perf counters when
//   COMMIT_PERF_CNT_EN is defined.
module tb_rob_commit_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [9:0]  in_rd;
  logic [1:0]  in_rd_we;
  logic [63:0] in_data;
  logic [1:0]  in_exc;
  logic [63:0] in_pc;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [1:0]  commit_cnt;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] perf_retired;
  logic [31:0] perf_flushes;
`endif

  int totalChecks  = 0;
  int passedChecks = 0;

  rob_commit_stage #(
    .RETIRE_WIDTH (2),
    .NUM_RD_PORTS (2),
    .FLUSH_CYCLES (3),
    .EXC_VECTOR   (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .in_data     (in_data),
    .in_exc      (in_exc),
    .in_pc       (in_pc),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .commit_cnt  (commit_cnt)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .perf_retired (perf_retired),
    .perf_flushes (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    totalChecks++;
    if (got === exp) passedChecks++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Presents one cycle of retiring entries, then withdraws valid.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we, input logic [1:0] exc,
                               input logic [4:0] rd0, input logic [31:0] d0, input logic [31:0] pc0,
                               input logic [4:0] rd1, input logic [31:0] d1, input logic [31:0] pc1);
    in_valid = valid;
    in_rd_we = we;
    in_exc   = exc;
    in_rd    = {rd1, rd0};
    in_data  = {d1, d0};
    in_pc    = {pc1, pc0};
    @(posedge clk);
    #1;
    in_valid = 2'b00;
  endtask

  // Reads a register through both read ports.
  task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rd_addr = {addr, addr};
    #1;
    checkOutput({tag, "_p0"}, {32'd0, rd_data[31:0]}, {32'd0, exp});
    checkOutput({tag, "_p1"}, {32'd0, rd_data[63:32]}, {32'd0, exp});
  endtask

  // Counts cycles with in_ready low, keeping offered inputs asserted the
  // whole time so any leak would show up in the registers or epc.
  task automatic waitReady(output int lowCycles);
    lowCycles = 0;
    while (!in_ready && lowCycles < 20) begin
      lowCycles++;
      @(posedge clk);
      #1;
    end
    in_valid = 2'b00;
  endtask

  initial begin
    int lowCycles;
    rst      = 1'b1;
    in_valid = '0;
    in_rd    = '0;
    in_rd_we = '0;
    in_data  = '0;
    in_exc   = '0;
    in_pc    = '0;
    rd_addr  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_flush", {63'd0, flush}, 64'd0);
    checkOutput("rst_redir", {32'd0, redirect_pc}, 64'd0);
    checkOutput("rst_epc", {32'd0, epc}, 64'd0);
    checkOutput("rst_cnt", {62'd0, commit_cnt}, 64'd0);
    checkReg("rst_r5", 5'd5, 32'd0);

    // Two-wide commit
    applyStimulus(2'b11, 2'b11, 2'b00, 5'd5, 32'hA5, 32'h0, 5'd6, 32'h5A, 32'h4);
    checkOutput("t1_cnt", {62'd0, commit_cnt}, 64'd2);
    checkReg("t1_r5", 5'd5, 32'hA5);
    checkReg("t1_r6", 5'd6, 32'h5A);

    // Same destination: youngest wins; writes to reg 0 dropped
    applyStimulus(2'b11, 2'b11, 2'b00, 5'd7, 32'h11, 32'h8, 5'd7, 32'h22, 32'hC);
    checkReg("t2_r7", 5'd7, 32'h22);
    applyStimulus(2'b11, 2'b11, 2'b00, 5'd0, 32'hFF, 32'h10, 5'd0, 32'hEE, 32'h14);
    checkReg("t2_r0", 5'd0, 32'h0);
    checkOutput("t2_cnt", {62'd0, commit_cnt}, 64'd2);

    // Valid prefix handling
    applyStimulus(2'b10, 2'b11, 2'b00, 5'd9, 32'h77, 32'h18, 5'd8, 32'h88, 32'h1C);
    checkOutput("t3a_cnt", {62'd0, commit_cnt}, 64'd0);
    checkReg("t3a_r8", 5'd8, 32'h0);
    applyStimulus(2'b01, 2'b11, 2'b00, 5'd9, 32'h99, 32'h20, 5'd10, 32'hAA, 32'h24);
    checkOutput("t3b_cnt", {62'd0, commit_cnt}, 64'd1);
    checkReg("t3b_r9", 5'd9, 32'h99);
    checkReg("t3b_r10", 5'd10, 32'h0);

    // Exception in slot 1: slot 0 commits, slot 1 discarded
    applyStimulus(2'b11, 2'b11, 2'b10, 5'd3, 32'h33, 32'h3C, 5'd4, 32'h44, 32'h40);
    checkOutput("t4_cnt", {62'd0, commit_cnt}, 64'd1);
    checkReg("t4_r3", 5'd3, 32'h33);
    checkReg("t4_r4", 5'd4, 32'h0);
    checkOutput("t4_epc", {32'd0, epc}, 64'h40);
    checkOutput("t4_flush", {63'd0, flush}, 64'd1);
    checkOutput("t4_redir", {32'd0, redirect_pc}, 64'h100);
    checkOutput("t4_ready", {63'd0, in_ready}, 64'd0);
    // Offer an excepting pair during the window; it must be ignored
    in_valid = 2'b11; in_rd_we = 2'b11; in_exc = 2'b01;
    in_rd = {5'd12, 5'd11}; in_data = {32'hCC, 32'hBB}; in_pc = {32'h84, 32'h80};
    waitReady(lowCycles);
    checkOutput("t4_lowcyc", lowCycles, 64'd4);
    checkOutput("t4_flush_end", {63'd0, flush}, 64'd0);
    checkOutput("t4_redir_end", {32'd0, redirect_pc}, 64'd0);
    checkOutput("t4_cnt_drop", {62'd0, commit_cnt}, 64'd0);
    checkOutput("t4_epc_kept", {32'd0, epc}, 64'h40);
    checkReg("t4_r11", 5'd11, 32'h0);

    // Exception in slot 0 with both valid: nothing commits
    applyStimulus(2'b11, 2'b11, 2'b01, 5'd13, 32'hDD, 32'h60, 5'd12, 32'hCC, 32'h64);
    checkOutput("t4b_cnt", {62'd0, commit_cnt}, 64'd0);
    checkReg("t4b_r13", 5'd13, 32'h0);
    checkReg("t4b_r12", 5'd12, 32'h0);
    checkOutput("t4b_epc", {32'd0, epc}, 64'h60);
    checkOutput("t4b_flush", {63'd0, flush}, 64'd1);
    waitReady(lowCycles);
    checkOutput("t4b_lowcyc", lowCycles, 64'd4);

    // Reset while draining
    applyStimulus(2'b01, 2'b01, 2'b01, 5'd14, 32'hEE, 32'h70, 5'd0, 32'h0, 32'h0);
    checkOutput("t5_flush", {63'd0, flush}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("t5_drain_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("t5_drain_flush", {63'd0, flush}, 64'd0);
    rst = 1'b1;
    #2;
    checkOutput("t5_rst_epc", {32'd0, epc}, 64'd0);
    checkOutput("t5_rst_flush", {63'd0, flush}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t5_ready", {63'd0, in_ready}, 64'd1);
    checkReg("t5_r3", 5'd3, 32'h0);
    checkReg("t5_r7", 5'd7, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t5_ready2", {63'd0, in_ready}, 64'd1);
    checkOutput("t5_flush2", {63'd0, flush}, 64'd0);

`ifdef COMMIT_PERF_CNT_EN
    checkOutput("t6_rst_ret", perf_retired, 64'd0);
    checkOutput("t6_rst_fl", {32'd0, perf_flushes}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b11, 2'b11, 2'b00, 5'd1, 32'(i), 32'h0, 5'd2, 32'(i + 1), 32'h4);
    end
    applyStimulus(2'b11, 2'b11, 2'b01, 5'd1, 32'h5, 32'h90, 5'd2, 32'h6, 32'h94);
    waitReady(lowCycles);
    checkOutput("t6_ret", perf_retired, 64'd20);
    checkOutput("t6_fl", {32'd0, perf_flushes}, 64'd1);
`endif

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
